// File: rtl/dds_pkg.sv
// Shared DDS definitions: phase/word widths and the measurement FSM state type.
package dds_pkg;

    localparam int unsigned PHASE_W = 32;
    localparam int unsigned PWORD_W = 11;
    localparam int unsigned PSHIFT  = PHASE_W - PWORD_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GATE = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    // Phase word that cancels the accumulated phase prod (top PWORD_W bits), modulo 2^PWORD_W.
    function automatic logic [PWORD_W-1:0] phase_from_prod(input logic [PHASE_W-1:0] prod);
        return PWORD_W'(0) - PWORD_W'(prod >> PSHIFT);
    endfunction

endpackage

// File: rtl/dds_edge_sync.sv
// Multi-stage synchronizer for an asynchronous input plus rising-edge detect on the synchronized level.
module dds_edge_sync #(
    parameter int unsigned SYNC_FF = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [SYNC_FF-1:0] r_sync;
    logic               r_q_d;

    // Shift the async input through the synchronizer and keep one delayed copy for edge detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_q_d  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_FF-2:0], d};
            r_q_d  <= r_sync[SYNC_FF-1];
        end
    end

    assign q    = r_sync[SYNC_FF-1];
    assign rise = r_sync[SYNC_FF-1] & ~r_q_d;

endmodule

// File: rtl/dds_freq_meter.sv
// Square-wave meter: counts synchronized rising edges over a 2^GATE_LOG2-clock gate and recovers
// the DDS tuning word and start-of-gate phase word that would reproduce the measured wave.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int unsigned GATE_LOG2 = 10,
    parameter int unsigned SYNC_FF   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wave_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 valid,
    output logic [GATE_LOG2-1:0] edge_cnt,
    output logic [PHASE_W-1:0]   k_est,
    output logic [PWORD_W-1:0]   p_est,
    output logic                 no_edge
);

    localparam int unsigned         K_SHIFT   = PHASE_W - GATE_LOG2;
    localparam logic [GATE_LOG2-1:0] GATE_LAST = '1;
    localparam logic [GATE_LOG2-1:0] EDGE_MAX  = '1;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [GATE_LOG2-1:0]   r_gate_cnt;
    logic [GATE_LOG2-1:0]   r_edges;
    logic [GATE_LOG2-1:0]   r_dly;
    logic                   r_seen;

    logic                   r_busy;
    logic                   r_valid;
    logic [GATE_LOG2-1:0]   r_edge_cnt;
    logic [PHASE_W-1:0]     r_k_est;
    logic [PWORD_W-1:0]     r_p_est;
    logic                   r_no_edge;

    logic                   w_sync;
    logic                   w_rise;
    logic                   w_edge;
    logic                   w_accept;
    logic [PHASE_W-1:0]     w_k_n;
    logic [PHASE_W-1:0]     w_prod;
    logic [PWORD_W-1:0]     w_p_n;

    dds_edge_sync #(
        .SYNC_FF (SYNC_FF)
    ) u_edge_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (wave_in),
        .q    (w_sync),
        .rise (w_rise)
    );

    assign w_edge   = w_rise & w_sync;
    assign w_accept = (r_state == IDLE) && start;

    // Estimates from the closed gate; only the low PHASE_W bits of the product matter.
    assign w_k_n  = PHASE_W'(r_edges) << K_SHIFT;
    assign w_prod = w_k_n * PHASE_W'(r_dly);
    assign w_p_n  = phase_from_prod(w_prod);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = GATE;
            GATE:    if (r_gate_cnt == GATE_LAST) w_state_nxt = CALC;
            CALC:    w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gate counter, saturating edge counter and first-edge delay latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gate_cnt <= '0;
            r_edges    <= '0;
            r_dly      <= '0;
            r_seen     <= 1'b0;
        end else if (w_accept) begin
            r_gate_cnt <= '0;
            r_edges    <= '0;
            r_dly      <= '0;
            r_seen     <= 1'b0;
        end else if (r_state == GATE) begin
            r_gate_cnt <= r_gate_cnt + 1'b1;
            if (w_edge) begin
                if (r_edges != EDGE_MAX) begin
                    r_edges <= r_edges + 1'b1;
                end
                if (!r_seen) begin
                    r_seen <= 1'b1;
                    r_dly  <= r_gate_cnt;
                end
            end
        end
    end

    // Status flags follow the next state; results load leaving CALC so they appear with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_edge_cnt <= '0;
            r_k_est    <= '0;
            r_p_est    <= '0;
            r_no_edge  <= 1'b0;
        end else begin
            r_busy  <= (w_state_nxt == GATE) || (w_state_nxt == CALC);
            r_valid <= (w_state_nxt == DONE);
            if (r_state == CALC) begin
                r_edge_cnt <= r_edges;
                r_k_est    <= w_k_n;
                r_p_est    <= w_p_n;
                r_no_edge  <= (r_edges == '0);
            end
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign edge_cnt = r_edge_cnt;
    assign k_est    = r_k_est;
    assign p_est    = r_p_est;
    assign no_edge  = r_no_edge;

endmodule

// File: tb/tb_dds_freq_meter.sv
// Directed bench for dds_freq_meter (GATE_LOG2=10, SYNC_FF=2) with hand-computed expectations.
module tb_dds_freq_meter;

    localparam int unsigned GL = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          wave_in;
    logic          start;
    logic          busy;
    logic          valid;
    logic [GL-1:0] edge_cnt;
    logic [31:0]   k_est;
    logic [10:0]   p_est;
    logic          no_edge;

    int npass  = 0;
    int nfail  = 0;
    int ntotal = 0;
    int wmode  = 0;
    int wph    = 0;
    int per    = 64;

    always #5 clk = ~clk;

    dds_freq_meter #(
        .GATE_LOG2 (GL),
        .SYNC_FF   (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wave_in  (wave_in),
        .start    (start),
        .busy     (busy),
        .valid    (valid),
        .edge_cnt (edge_cnt),
        .k_est    (k_est),
        .p_est    (p_est),
        .no_edge  (no_edge)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and drive the wave for that cycle.
    task automatic tick();
        @(negedge clk);
        case (wmode)
            0:       wave_in = 1'b0;
            1:       wave_in = ~wave_in;
            default: wave_in = ((wph % per) < (per / 2));
        endcase
        wph++;
    endtask

    // Pre-roll the wave so its phase counter equals ph0 (mod period) on the start cycle, then request start.
    task automatic launch(input int mode, input int period, input int ph0);
        wmode = mode;
        per   = period;
        wph   = ph0 + 640 - 100;
        repeat (100) tick();
        tick();
        start = 1'b1;
    endtask

    // Wait (bounded) for valid; optionally pulse a stray start at cycle ign_at.
    task automatic wait_done(input int ign_at, output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 1500; n++) begin
            tick();
            start = (n == ign_at);
            if (valid === 1'b1) begin
                lat = n;
                break;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        start = (ign_at < 0) ? 1'b0 : start;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit bok;
        int nv;

        rst     = 1'b1;
        start   = 1'b0;
        wave_in = 1'b0;

        // Reset with the wave toggling.
        wmode = 1;
        repeat (3) tick();
        chk("rst_busy",    32'(busy),     32'd0);
        chk("rst_valid",   32'(valid),    32'd0);
        chk("rst_edge",    32'(edge_cnt), 32'd0);
        chk("rst_k",       k_est,         32'd0);
        chk("rst_p",       32'(p_est),    32'd0);
        chk("rst_no_edge", 32'(no_edge),  32'd0);
        rst = 1'b0;
        tick();
        chk("idle_busy",  32'(busy),  32'd0);
        chk("idle_valid", 32'(valid), 32'd0);

        // Period 64, first synchronized rise in gate cycle 16.
        launch(2, 64, 49);
        wait_done(0, lat, bok);
        chk("p64_latency", 32'(lat),      32'd1026);
        chk("p64_busy",    32'(bok),      32'd1);
        chk("p64_busy_dn", 32'(busy),     32'd0);
        chk("p64_edge",    32'(edge_cnt), 32'd16);
        chk("p64_k",       k_est,         32'h0400_0000);
        chk("p64_p",       32'(p_est),    32'd1536);
        chk("p64_no_edge", 32'(no_edge),  32'd0);
        tick();
        chk("p64_pulse",   32'(valid),    32'd0);
        chk("p64_hold_k",  k_est,         32'h0400_0000);

        // Period 64, rise in gate cycle 0; stray starts mid-gate and in DONE.
        launch(2, 64, 1);
        wait_done(500, lat, bok);
        chk("c0_latency", 32'(lat),      32'd1026);
        chk("c0_busy",    32'(bok),      32'd1);
        chk("c0_edge",    32'(edge_cnt), 32'd16);
        chk("c0_k",       k_est,         32'h0400_0000);
        chk("c0_p",       32'(p_est),    32'd0);
        start = 1'b1;
        wmode = 0;
        tick();
        chk("done_start_ign_busy",  32'(busy),  32'd0);
        chk("done_start_ign_valid", 32'(valid), 32'd0);

        // Start right after DONE is accepted; wave held low gives no edges.
        start = 1'b1;
        wait_done(0, lat, bok);
        chk("zero_latency", 32'(lat),      32'd1026);
        chk("zero_busy",    32'(bok),      32'd1);
        chk("zero_no_edge", 32'(no_edge),  32'd1);
        chk("zero_edge",    32'(edge_cnt), 32'd0);
        chk("zero_k",       k_est,         32'd0);
        chk("zero_p",       32'(p_est),    32'd0);

        // Period 32, rises from gate cycle 31 through the last gate cycle 1023.
        launch(2, 32, 2);
        wait_done(0, lat, bok);
        chk("p32_latency", 32'(lat),      32'd1026);
        chk("p32_edge",    32'(edge_cnt), 32'd32);
        chk("p32_k",       k_est,         32'h0800_0000);
        chk("p32_p",       32'(p_est),    32'd64);
        chk("p32_no_edge", 32'(no_edge),  32'd0);

        // Reset in the middle of a gate aborts and clears results.
        launch(2, 64, 49);
        tick();
        start = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        repeat (299) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy",    32'(busy),     32'd0);
        chk("abort_valid",   32'(valid),    32'd0);
        chk("abort_edge",    32'(edge_cnt), 32'd0);
        chk("abort_k",       k_est,         32'd0);
        chk("abort_p",       32'(p_est),    32'd0);
        chk("abort_no_edge", 32'(no_edge),  32'd0);
        nv = 0;
        repeat (1200) begin
            tick();
            if (valid === 1'b1) nv++;
        end
        chk("abort_no_valid", 32'(nv),   32'd0);
        chk("abort_idle",     32'(busy), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
